// File: rtl/add_pipe_arbiter.sv
// rtl/add_pipe_arbiter.sv - two-requester arbiter in front of a shared two-stage A+B+D pipeline
// Define ADD_PIPE_ARB_RR_EN for round-robin tie-break; otherwise requester 0 wins ties.
module add_pipe_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   IN_REQ,
  input  logic [W-1:0] IN_A0,
  input  logic [W-1:0] IN_B0,
  input  logic [W-1:0] IN_D0,
  input  logic [W-1:0] IN_A1,
  input  logic [W-1:0] IN_B1,
  input  logic [W-1:0] IN_D1,
  output logic [1:0]   OUT_GNT,
  output logic         OUT_VALID,
  output logic         OUT_ID,
  output logic [W+1:0] OUT_E,
  input  logic         IN_READY,
  output logic         OUT_BUSY
);

  logic         s1_valid_q, s1_valid_d;
  logic         s1_id_q, s1_id_d;
  logic [W:0]   s1_c_q, s1_c_d;
  logic [W-1:0] s1_d_q, s1_d_d;
  logic         out_valid_q, out_valid_d;
  logic         out_id_q, out_id_d;
  logic [W+1:0] out_e_q, out_e_d;
  logic         stall;
  logic [1:0]   gnt;

  assign stall = out_valid_q & ~IN_READY;

`ifdef ADD_PIPE_ARB_RR_EN
  logic last_q, last_d;

  always_comb begin
    gnt = 2'b00;
    if (!rst && !stall) begin
      unique case (IN_REQ)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // gnt is only ever set on a requesting bit, so any grant is a transfer
  always_comb begin
    last_d = last_q;
    if (|gnt) last_d = gnt[1];
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`else
  always_comb begin
    gnt = 2'b00;
    if (!rst && !stall) begin
      if (IN_REQ[0])      gnt = 2'b01;
      else if (IN_REQ[1]) gnt = 2'b10;
    end
  end
`endif

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_id_d     = s1_id_q;
    s1_c_d      = s1_c_q;
    s1_d_d      = s1_d_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_e_d     = out_e_q;
    if (!stall) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_id_d = s1_id_q;
        out_e_d  = {1'b0, s1_c_q} + {2'b00, s1_d_q};
      end
      s1_valid_d = |gnt;
      if (gnt[0]) begin
        s1_id_d = 1'b0;
        s1_c_d  = {1'b0, IN_A0} + {1'b0, IN_B0};
        s1_d_d  = IN_D0;
      end else if (gnt[1]) begin
        s1_id_d = 1'b1;
        s1_c_d  = {1'b0, IN_A1} + {1'b0, IN_B1};
        s1_d_d  = IN_D1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_id_q     <= 1'b0;
      s1_c_q      <= '0;
      s1_d_q      <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      out_e_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      s1_c_q      <= s1_c_d;
      s1_d_q      <= s1_d_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_e_q     <= out_e_d;
    end
  end

  assign OUT_GNT   = gnt;
  assign OUT_VALID = out_valid_q;
  assign OUT_ID    = out_id_q;
  assign OUT_E     = out_e_q;
  assign OUT_BUSY  = s1_valid_q | out_valid_q;

endmodule

// File: tb/tb_add_pipe_arbiter.sv
// tb/tb_add_pipe_arbiter.sv - directed self-checking bench for add_pipe_arbiter
module tb_add_pipe_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] IN_REQ;
  logic [3:0] IN_A0, IN_B0, IN_D0, IN_A1, IN_B1, IN_D1;
  logic [1:0] OUT_GNT;
  logic       OUT_VALID, OUT_ID, IN_READY, OUT_BUSY;
  logic [5:0] OUT_E;

  int tests = 0;
  int fails = 0;

  add_pipe_arbiter #(.W(4)) dut (
    .clk(clk), .rst(rst), .IN_REQ(IN_REQ),
    .IN_A0(IN_A0), .IN_B0(IN_B0), .IN_D0(IN_D0),
    .IN_A1(IN_A1), .IN_B1(IN_B1), .IN_D1(IN_D1),
    .OUT_GNT(OUT_GNT), .OUT_VALID(OUT_VALID), .OUT_ID(OUT_ID),
    .OUT_E(OUT_E), .IN_READY(IN_READY), .OUT_BUSY(OUT_BUSY)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic id, input logic [5:0] e);
    chk({tag, "_valid"}, {7'd0, OUT_VALID}, {7'd0, v});
    if (v) begin
      chk({tag, "_id"}, {7'd0, OUT_ID}, {7'd0, id});
      chk({tag, "_e"}, {2'd0, OUT_E}, {2'd0, e});
    end
  endtask

  logic [1:0] exp_gnt [4];
  logic       exp_id  [4];
  logic [5:0] exp_e   [4];

  initial begin
`ifdef ADD_PIPE_ARB_RR_EN
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_id  = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_e   = '{6'd3, 6'd6, 6'd3, 6'd6};
`else
    exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
    exp_id  = '{1'b0, 1'b0, 1'b0, 1'b0};
    exp_e   = '{6'd3, 6'd3, 6'd3, 6'd3};
`endif
    rst = 1'b1; IN_REQ = 2'b01; IN_READY = 1'b1;
    IN_A0 = 4'd0; IN_B0 = 4'd0; IN_D0 = 4'd0;
    IN_A1 = 4'd0; IN_B1 = 4'd0; IN_D1 = 4'd0;
    step(); step();
    chk("rst_gnt", {6'd0, OUT_GNT}, 8'd0);
    chk("rst_valid", {7'd0, OUT_VALID}, 8'd0);
    chk("rst_id", {7'd0, OUT_ID}, 8'd0);
    chk("rst_e", {2'd0, OUT_E}, 8'd0);
    chk("rst_busy", {7'd0, OUT_BUSY}, 8'd0);

    // idle
    IN_REQ = 2'b00; rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_busy", {7'd0, OUT_BUSY}, 8'd0);
      chk("idle_valid", {7'd0, OUT_VALID}, 8'd0);
      chk("idle_gnt", {6'd0, OUT_GNT}, 8'd0);
    end

    // single op, requester 0: 3+5+9
    IN_REQ = 2'b01; IN_A0 = 4'd3; IN_B0 = 4'd5; IN_D0 = 4'd9;
    #1 chk("single_gnt", {6'd0, OUT_GNT}, 8'd1);
    step(); IN_REQ = 2'b00;
    chk("single_busy", {7'd0, OUT_BUSY}, 8'd1);
    chk_out("single_lat1", 1'b0, 1'b0, 6'd0);
    step();
    chk_out("single", 1'b1, 1'b0, 6'd17);
    step();
    chk_out("single_after", 1'b0, 1'b0, 6'd0);

    // max operands
    IN_REQ = 2'b01; IN_A0 = 4'd15; IN_B0 = 4'd15; IN_D0 = 4'd15;
    step(); IN_REQ = 2'b00;
    step();
    chk_out("max", 1'b1, 1'b0, 6'd45);

    // single op, requester 1: 7+2+1
    IN_REQ = 2'b10; IN_A1 = 4'd7; IN_B1 = 4'd2; IN_D1 = 4'd1;
    #1 chk("r1_gnt", {6'd0, OUT_GNT}, 8'd2);
    step(); IN_REQ = 2'b00;
    step();
    chk_out("r1", 1'b1, 1'b1, 6'd10);
    step();

    // contention from a fresh reset
    rst = 1'b1; step(); rst = 1'b0;
    IN_A0 = 4'd1; IN_B0 = 4'd1; IN_D0 = 4'd1;
    IN_A1 = 4'd2; IN_B1 = 4'd2; IN_D1 = 4'd2;
    IN_REQ = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cont_gnt%0d", i), {6'd0, OUT_GNT}, {6'd0, exp_gnt[i]});
      step();
      if (i >= 1) chk_out($sformatf("cont_res%0d", i - 1), 1'b1, exp_id[i-1], exp_e[i-1]);
    end
    IN_REQ = 2'b00;
    step();
    chk_out("cont_res3", 1'b1, exp_id[3], exp_e[3]);
    step();
    chk_out("cont_drain", 1'b0, 1'b0, 6'd0);

    // backpressure with two ops in flight: 1+2+3 then 4+4+4
    IN_REQ = 2'b01; IN_A0 = 4'd1; IN_B0 = 4'd2; IN_D0 = 4'd3;
    step();
    IN_REQ = 2'b10; IN_A1 = 4'd4; IN_B1 = 4'd4; IN_D1 = 4'd4;
    #1 chk("bp_gnt_y", {6'd0, OUT_GNT}, 8'd2);
    step();
    IN_REQ = 2'b00; IN_READY = 1'b0;
    chk_out("bp_x", 1'b1, 1'b0, 6'd6);
    #1 chk("bp_stall_gnt", {6'd0, OUT_GNT}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        IN_REQ = 2'b10; IN_A1 = 4'd9; IN_B1 = 4'd9; IN_D1 = 4'd9;
        #1 chk("wd_gnt", {6'd0, OUT_GNT}, 8'd0);
      end
      step();
      IN_REQ = 2'b00;
      chk_out($sformatf("bp_hold%0d", i), 1'b1, 1'b0, 6'd6);
      chk("bp_busy", {7'd0, OUT_BUSY}, 8'd1);
    end
    IN_READY = 1'b1;
    step();
    chk_out("bp_y", 1'b1, 1'b1, 6'd12);
    step();
    chk_out("bp_empty", 1'b0, 1'b0, 6'd0);
    step();
    chk_out("wd_no_result", 1'b0, 1'b0, 6'd0);
    chk("wd_busy", {7'd0, OUT_BUSY}, 8'd0);
    // last was set by op Y (requester 1); the withdrawn pulse must not change that
    IN_REQ = 2'b11;
    #1 chk("wd_tie_gnt", {6'd0, OUT_GNT}, 8'd1);
    IN_REQ = 2'b00;

    // reset mid-flight
    IN_REQ = 2'b01; IN_A0 = 4'd2; IN_B0 = 4'd2; IN_D0 = 4'd2;
    step(); step();
    chk("mid_valid", {7'd0, OUT_VALID}, 8'd1);
    chk("mid_busy", {7'd0, OUT_BUSY}, 8'd1);
    rst = 1'b1;
    #1 chk("mid_rst_gnt", {6'd0, OUT_GNT}, 8'd0);
    IN_REQ = 2'b00;
    step();
    chk("mid_rst_valid", {7'd0, OUT_VALID}, 8'd0);
    chk("mid_rst_e", {2'd0, OUT_E}, 8'd0);
    chk("mid_rst_id", {7'd0, OUT_ID}, 8'd0);
    chk("mid_rst_busy", {7'd0, OUT_BUSY}, 8'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_valid", {7'd0, OUT_VALID}, 8'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/add_pipe_arbiter.md
# add_pipe_arbiter

Shares one two-stage add pipeline (stage 1: c = A + B; stage 2: E = c + D) between two requesters. Round-robin arbitration accepts at most one operation per cycle, tags it with the requester ID, and returns the result on a shared output port with valid/ready flow control. It sits in front of the shared add datapath; each requester holds its operands until granted.

## Interface
- W, 4, operand width for A, B and D
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- IN_REQ  in  2  per-requester request; bit n = requester n
- IN_A0, IN_B0, IN_D0  in  W each  requester 0 operands, valid while IN_REQ[0]=1
- IN_A1, IN_B1, IN_D1  in  W each  requester 1 operands, valid while IN_REQ[1]=1
- OUT_GNT  out  2  combinational grant, one-hot or zero; transfer when IN_REQ[n] & OUT_GNT[n] at rising clk
- OUT_VALID  out  1  result valid
- OUT_ID  out  1  requester that issued the result
- OUT_E  out  W+2  result A + B + D, zero-extended, never overflows
- IN_READY  in  1  consumer accepts the result when OUT_VALID & IN_READY at rising clk
- OUT_BUSY  out  1  high when stage 1 or the output stage holds a valid op

## Operation
- Stage 1 registers: s1_valid, s1_id, s1_c (W+1 bits) = A + B, and s1_d (W bits) = D of the granted requester.
- Output stage registers: OUT_VALID, OUT_ID, and OUT_E = s1_c + s1_d (W+2 bits).
- stall = OUT_VALID & ~IN_READY. During stall, both stages hold their contents and OUT_GNT = 00.
- When not stalled, each rising edge moves stage 1 into the output stage and loads stage 1 from the granted request. If nothing is granted, stage 1 loads a bubble (s1_valid = 0).
- Arbitration uses a 1-bit pointer `last`, the ID most recently granted:
  - only REQ[n] high: grant n.
  - both high: grant the requester that is not `last`.
  - `last` updates only on a completed transfer.
- Grant is a function of this cycle's IN_REQ, `last` and stall only. It does not depend on stage-1 occupancy, because the pipeline advances whenever not stalled.
- Requesters must keep IN_REQ and operands stable until granted. Dropping IN_REQ before grant withdraws the request with no side effect.
- OUT_BUSY = s1_valid | OUT_VALID.
- Reset values: s1_valid = 0, s1_id = 0, s1_c = 0, s1_d = 0, OUT_VALID = 0, OUT_ID = 0, OUT_E = 0, `last` = 1 (requester 0 wins the first tie). OUT_GNT = 00 while rst = 1.
- Reset mid-operation: all in-flight operations are discarded. No OUT_VALID is produced for them after reset deasserts.

## Timing
- Latency: a request granted at edge k appears with OUT_VALID = 1 after edge k+1, two cycles from grant to result.
- Throughput: one operation per cycle with IN_READY held at 1. Alternating requesters sustain full rate.
- Stall at edge j: OUT_E, OUT_ID, OUT_VALID, s1_* and `last` are unchanged after edge j, and OUT_GNT = 00 throughout the stall cycle.
- A result is consumed and replaced in the same edge when IN_READY = 1 and s1_valid = 1. There is no bubble between back-to-back results.
- OUT_GNT is combinational from IN_REQ, `last`, OUT_VALID and IN_READY. All other outputs are registered.

## Configuration
- ADD_PIPE_ARB_RR_EN defined: round-robin tie-break via `last`, as above.
- ADD_PIPE_ARB_RR_EN undefined: fixed priority, requester 0 always wins ties. `last` is not implemented. All other behaviour and timing are identical.

## Test plan
- Single op, W=4: requester 0 drives A=3, B=5, D=9, IN_READY=1 -> OUT_GNT=01 that cycle; two cycles later OUT_VALID=1, OUT_ID=0, OUT_E=17. Max case A=B=D=15 -> OUT_E=45.
- Contention with RR: IN_REQ=11 held for 4 cycles after reset -> grant order 0,1,0,1. Results appear in that order with OUT_ID 0,1,0,1 on consecutive cycles. Without the macro -> grant order 0,0,0,0.
- Backpressure: two ops in flight, IN_READY=0 for 3 cycles -> OUT_VALID stays 1 with OUT_E and OUT_ID frozen, OUT_GNT=00. IN_READY returns to 1 -> the first result is consumed, the second appears on the next cycle, and none are lost or duplicated.
- Withdrawal: IN_REQ[1] pulses high for one cycle during a stall, then drops -> no grant to requester 1, no result for requester 1, `last` unchanged.
- Reset mid-flight: assert rst with s1_valid=1 and OUT_VALID=1 -> after the reset edge all outputs are at reset values, and no OUT_VALID appears in the 3 cycles after rst deasserts with IN_REQ=00.
- Idle: IN_REQ=00 for 5 cycles after reset -> OUT_BUSY=0, OUT_VALID=0, OUT_GNT=00.
